// File: rtl/cc_seq_controller_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcode fields,
// branch condition codes and IR field positions.
package cc_seq_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_BRANCH = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [3:0] COND_N   = 4'b0000;
    localparam logic [3:0] COND_E   = 4'b0001;
    localparam logic [3:0] COND_LE  = 4'b0010;
    localparam logic [3:0] COND_L   = 4'b0011;
    localparam logic [3:0] COND_LEU = 4'b0100;
    localparam logic [3:0] COND_CS  = 4'b0101;
    localparam logic [3:0] COND_NEG = 4'b0110;
    localparam logic [3:0] COND_VS  = 4'b0111;
    localparam logic [3:0] COND_A   = 4'b1000;
    localparam logic [3:0] COND_NE  = 4'b1001;
    localparam logic [3:0] COND_G   = 4'b1010;
    localparam logic [3:0] COND_GE  = 4'b1011;
    localparam logic [3:0] COND_GU  = 4'b1100;
    localparam logic [3:0] COND_CC  = 4'b1101;
    localparam logic [3:0] COND_POS = 4'b1110;
    localparam logic [3:0] COND_VC  = 4'b1111;

    localparam int IR_OP_HI   = 31;
    localparam int IR_OP_LO   = 30;
    localparam int IR_COND_HI = 28;
    localparam int IR_COND_LO = 25;
    localparam int IR_OP2_HI  = 24;
    localparam int IR_OP2_LO  = 22;
    localparam int IR_CC_BIT  = 23;
    localparam int IR_ALU_HI  = 22;
    localparam int IR_ALU_LO  = 19;

    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_V = 1;
    localparam int PSR_C = 0;

endpackage

// File: rtl/cc_seq_controller_if.sv
// Bundle of the sequencer's memory, PSR and datapath-control signals.
// The master side is the sequencer; the slave side is memory plus datapath.
interface cc_seq_controller_if #(
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_INSTR         = 32
);
    logic                               CC_SEQ_START;
    logic [DATAWIDTH_INSTR-1:0]         CC_SEQ_INSTR;
    logic                               CC_SEQ_INSTR_VALID;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQ_PSR;
    logic                               CC_SEQ_FETCH_REQ;
    logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQ_ALU_SEL;
    logic                               CC_SEQ_SET_CONDITIONS;
    logic                               CC_SEQ_REG_WE;
    logic                               CC_SEQ_PC_INC;
    logic                               CC_SEQ_PC_LOAD;
    logic                               CC_SEQ_BRANCH_TAKEN;
    logic                               CC_SEQ_BUSY;
    logic                               CC_SEQ_HALTED;
    logic                               CC_SEQ_FAULT;

    modport master (
        input  CC_SEQ_START, CC_SEQ_INSTR, CC_SEQ_INSTR_VALID, CC_SEQ_PSR,
        output CC_SEQ_FETCH_REQ, CC_SEQ_ALU_SEL, CC_SEQ_SET_CONDITIONS,
               CC_SEQ_REG_WE, CC_SEQ_PC_INC, CC_SEQ_PC_LOAD,
               CC_SEQ_BRANCH_TAKEN, CC_SEQ_BUSY, CC_SEQ_HALTED, CC_SEQ_FAULT
    );

    modport slave (
        output CC_SEQ_START, CC_SEQ_INSTR, CC_SEQ_INSTR_VALID, CC_SEQ_PSR,
        input  CC_SEQ_FETCH_REQ, CC_SEQ_ALU_SEL, CC_SEQ_SET_CONDITIONS,
               CC_SEQ_REG_WE, CC_SEQ_PC_INC, CC_SEQ_PC_LOAD,
               CC_SEQ_BRANCH_TAKEN, CC_SEQ_BUSY, CC_SEQ_HALTED, CC_SEQ_FAULT
    );
endinterface

// File: rtl/cc_seq_controller_cond_eval.sv
// Combinational Bicc condition evaluator: 4-bit cond against PSR {N,Z,V,C}.
module cc_cond_eval
    import cc_seq_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] psr,
    output logic       taken
);
    logic n, z, v, c;

    always_comb begin
        n     = psr[PSR_N];
        z     = psr[PSR_Z];
        v     = psr[PSR_V];
        c     = psr[PSR_C];
        taken = 1'b0;
        case (cond)
            COND_N:   taken = 1'b0;
            COND_E:   taken = z;
            COND_LE:  taken = z | (n ^ v);
            COND_L:   taken = n ^ v;
            COND_LEU: taken = c | z;
            COND_CS:  taken = c;
            COND_NEG: taken = n;
            COND_VS:  taken = v;
            COND_A:   taken = 1'b1;
            COND_NE:  taken = ~z;
            COND_G:   taken = ~(z | (n ^ v));
            COND_GE:  taken = ~(n ^ v);
            COND_GU:  taken = ~(c | z);
            COND_CC:  taken = ~c;
            COND_POS: taken = ~n;
            COND_VC:  taken = ~v;
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cc_seq_controller.sv
// Multi-cycle fetch/decode/execute sequencer; all control outputs are decoded
// combinationally from the current state, the latched IR and the live PSR.
module cc_seq_controller
    import cc_seq_controller_pkg::*;
#(
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_INSTR         = 32,
    parameter int FETCH_TIMEOUT           = 15
) (
    input  logic CC_SEQ_CLOCK_50,
    input  logic CC_SEQ_RESET_InLow,
    cc_seq_controller_if.master bus
);
    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_t                     state_q, state_d;
    logic [DATAWIDTH_INSTR-1:0] ir_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       taken;

    cc_cond_eval u_cond_eval (
        .cond  (ir_q[IR_COND_HI:IR_COND_LO]),
        .psr   (bus.CC_SEQ_PSR[3:0]),
        .taken (taken)
    );

    always_ff @(posedge CC_SEQ_CLOCK_50 or negedge CC_SEQ_RESET_InLow) begin
        if (!CC_SEQ_RESET_InLow) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH) begin
                if (bus.CC_SEQ_INSTR_VALID) begin
                    ir_q  <= bus.CC_SEQ_INSTR;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // The final wait cycle is the one whose increment would reach FETCH_TIMEOUT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.CC_SEQ_START) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.CC_SEQ_INSTR_VALID)  state_d = ST_DECODE;
                else if (cnt_q == CNT_LAST)  state_d = ST_FAULT;
            end
            ST_DECODE: begin
                if (ir_q == '0)
                    state_d = ST_HALT;
                else if (ir_q[IR_OP_HI:IR_OP_LO] == OP_ARITH)
                    state_d = ST_EXEC;
                else if (ir_q[IR_OP_HI:IR_OP_LO] == OP_BRANCH &&
                         ir_q[IR_OP2_HI:IR_OP2_LO] == OP2_BICC)
                    state_d = ST_BRANCH;
                else
                    state_d = ST_FAULT;
            end
            ST_EXEC:   state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.CC_SEQ_FETCH_REQ      = 1'b0;
        bus.CC_SEQ_ALU_SEL        = '0;
        bus.CC_SEQ_SET_CONDITIONS = 1'b0;
        bus.CC_SEQ_REG_WE         = 1'b0;
        bus.CC_SEQ_PC_INC         = 1'b0;
        bus.CC_SEQ_PC_LOAD        = 1'b0;
        bus.CC_SEQ_BRANCH_TAKEN   = 1'b0;
        bus.CC_SEQ_BUSY           = 1'b0;
        bus.CC_SEQ_HALTED         = 1'b0;
        bus.CC_SEQ_FAULT          = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.CC_SEQ_FETCH_REQ = 1'b1;
                bus.CC_SEQ_BUSY      = 1'b1;
            end
            ST_DECODE: bus.CC_SEQ_BUSY = 1'b1;
            ST_EXEC: begin
                bus.CC_SEQ_BUSY           = 1'b1;
                bus.CC_SEQ_ALU_SEL        = DATAWIDTH_ALU_SELECTION'(ir_q[IR_ALU_HI:IR_ALU_LO]);
                bus.CC_SEQ_SET_CONDITIONS = ir_q[IR_CC_BIT];
                bus.CC_SEQ_REG_WE         = 1'b1;
                bus.CC_SEQ_PC_INC         = 1'b1;
            end
            ST_BRANCH: begin
                bus.CC_SEQ_BUSY         = 1'b1;
                bus.CC_SEQ_PC_LOAD      = taken;
                bus.CC_SEQ_BRANCH_TAKEN = taken;
                bus.CC_SEQ_PC_INC       = ~taken;
            end
            ST_HALT:  bus.CC_SEQ_HALTED = 1'b1;
            ST_FAULT: bus.CC_SEQ_FAULT  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cc_seq_controller.sv
// Scoreboard bench for cc_seq_controller: stimulus queues expected EXEC/BRANCH
// control pulses, a monitor pops and compares whenever the DUT emits one.
module tb_cc_seq_controller;
    import cc_seq_controller_pkg::*;

    typedef struct packed {
        logic [3:0] alu;
        logic       setcc;
        logic       we;
        logic       inc;
        logic       load;
        logic       taken;
        logic       busy;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_seq_controller_if #(.DATAWIDTH_ALU_SELECTION(4), .DATAWIDTH_INSTR(32)) bus ();

    cc_seq_controller #(
        .DATAWIDTH_ALU_SELECTION(4),
        .DATAWIDTH_INSTR(32),
        .FETCH_TIMEOUT(15)
    ) dut (
        .CC_SEQ_CLOCK_50    (clk),
        .CC_SEQ_RESET_InLow (rst_n),
        .bus                (bus)
    );

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    ev_t mon_got;
    ev_t mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.CC_SEQ_FETCH_REQ, bus.CC_SEQ_ALU_SEL, bus.CC_SEQ_SET_CONDITIONS,
                bus.CC_SEQ_REG_WE, bus.CC_SEQ_PC_INC, bus.CC_SEQ_PC_LOAD,
                bus.CC_SEQ_BRANCH_TAKEN, bus.CC_SEQ_BUSY, bus.CC_SEQ_HALTED,
                bus.CC_SEQ_FAULT};
    endfunction

    // Reference: cond[2:0] picks a base test, cond[3] inverts it.
    function automatic logic taken_ref(input logic [3:0] cond, input logic [3:0] psr);
        logic n, z, v, c, base;
        n = psr[3]; z = psr[2]; v = psr[1]; c = psr[0];
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            default: base = v;
        endcase
        return base ^ cond[3];
    endfunction

    function automatic logic [31:0] bicc(input logic [3:0] cond);
        return {2'b00, 1'b0, cond, 3'b010, 22'h0};
    endfunction

    function automatic logic [31:0] arith(input logic [5:0] op3);
        return {2'b10, 5'd3, op3, 5'd1, 1'b0, 8'd0, 5'd2};
    endfunction

    task automatic push_exec(input logic [3:0] alu, input logic cc);
        exp_q.push_back('{alu: alu, setcc: cc, we: 1'b1, inc: 1'b1, load: 1'b0, taken: 1'b0, busy: 1'b1});
    endtask

    task automatic push_br(input logic t);
        exp_q.push_back('{alu: 4'h0, setcc: 1'b0, we: 1'b0, inc: ~t, load: t, taken: t, busy: 1'b1});
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.CC_SEQ_FETCH_REQ) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_req_wait actual=timeout required=FETCH_REQ within 64 cycles");
        end
    endtask

    // Memory model: answers the pending fetch after lat wait cycles.
    task automatic serve(input logic [31:0] instr, input int lat, input logic [3:0] psr);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        bus.CC_SEQ_PSR = psr;
        repeat (lat) @(negedge clk);
        bus.CC_SEQ_INSTR       = instr;
        bus.CC_SEQ_INSTR_VALID = 1'b1;
        @(negedge clk);
        bus.CC_SEQ_INSTR_VALID = 1'b0;
        bus.CC_SEQ_INSTR       = '0;
    endtask

    task automatic do_start();
        bus.CC_SEQ_START = 1'b1;
        @(negedge clk);
        bus.CC_SEQ_START = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.CC_SEQ_REG_WE || bus.CC_SEQ_PC_INC || bus.CC_SEQ_PC_LOAD)) begin
            mon_got = '{alu: bus.CC_SEQ_ALU_SEL, setcc: bus.CC_SEQ_SET_CONDITIONS,
                        we: bus.CC_SEQ_REG_WE, inc: bus.CC_SEQ_PC_INC,
                        load: bus.CC_SEQ_PC_LOAD, taken: bus.CC_SEQ_BRANCH_TAKEN,
                        busy: bus.CC_SEQ_BUSY};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%h required=no control pulse", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("exec_event", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t0;
        bus.CC_SEQ_START       = 1'b0;
        bus.CC_SEQ_INSTR       = '0;
        bus.CC_SEQ_INSTR_VALID = 1'b0;
        bus.CC_SEQ_PSR         = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(all_outs()), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.CC_SEQ_BUSY), 32'h0);

        do_start();
        wait_req(ok);
        @(negedge clk);
        check("fetch_busy", 32'({bus.CC_SEQ_BUSY, bus.CC_SEQ_FETCH_REQ}), 32'h3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_midfetch_outputs", 32'(all_outs()), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'({bus.CC_SEQ_BUSY, bus.CC_SEQ_FETCH_REQ}), 32'h0);

        push_exec(4'b0000, 1'b1);
        do_start();
        wait_req(ok);
        t0 = cyc;
        serve(32'h8280_4002, 0, 4'h0);
        wait_req(ok);
        check("refetch_latency", 32'(cyc - t0), 32'd3);
        push_exec(4'b0111, 1'b0);
        serve(arith(6'b000111), 3, 4'h0);
        push_exec(4'b1010, 1'b1);
        serve(arith(6'b011010), 1, 4'h0);

        push_br(1'b1);
        serve(bicc(4'b0001), 0, 4'b0100);
        push_br(1'b0);
        serve(bicc(4'b0001), 0, 4'b0000);

        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 16; p++) begin
                push_br(taken_ref(4'(c), 4'(p)));
                serve(bicc(4'(c)), 0, 4'(p));
            end
        end

        push_exec(4'b0011, 1'b0);
        serve(arith(6'b000011), 13, 4'h0);

        wait_req(ok);
        repeat (14) @(negedge clk);
        check("fetch_cycle15", 32'({bus.CC_SEQ_FAULT, bus.CC_SEQ_FETCH_REQ}), 32'h1);
        @(negedge clk);
        check("timeout_fault", 32'({bus.CC_SEQ_FAULT, bus.CC_SEQ_FETCH_REQ, bus.CC_SEQ_BUSY}), 32'h4);
        do_start();
        @(negedge clk);
        check("fault_sticky", 32'({bus.CC_SEQ_FAULT, bus.CC_SEQ_FETCH_REQ, bus.CC_SEQ_BUSY}), 32'h4);

        pulse_reset();
        do_start();
        serve(32'h0000_0000, 0, 4'h0);
        repeat (2) @(negedge clk);
        check("halted", 32'({bus.CC_SEQ_HALTED, bus.CC_SEQ_BUSY, bus.CC_SEQ_FAULT}), 32'h4);
        do_start();
        repeat (3) @(negedge clk);
        check("halt_sticky", 32'({bus.CC_SEQ_HALTED, bus.CC_SEQ_BUSY, bus.CC_SEQ_FETCH_REQ}), 32'h4);

        pulse_reset();
        do_start();
        serve(32'hC000_0000, 0, 4'h0);
        repeat (4) @(negedge clk);
        check("illegal_op11_fault", 32'({bus.CC_SEQ_FAULT, bus.CC_SEQ_BUSY, bus.CC_SEQ_HALTED}), 32'h4);

        pulse_reset();
        do_start();
        serve(32'h0100_0000, 0, 4'h0);
        repeat (4) @(negedge clk);
        check("illegal_op2_fault", 32'({bus.CC_SEQ_FAULT, bus.CC_SEQ_BUSY, bus.CC_SEQ_HALTED}), 32'h4);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cc_seq_controller.md
Name: cc_seq_controller

Overview:
- Multi-cycle instruction sequencer for the ARC-style datapath.
- Fetches one 32-bit instruction per pass over a req/valid handshake and decodes it.
- Drives ALU selection, Set_Conditions_C to the PSR, register write enable and PC control.
- Resolves conditional branches against the 4-bit PSR flags {N,Z,V,C}. Sits between instruction memory, the register file/ALU and the PSR.

Parameters:
- DATAWIDTH_ALU_SELECTION, 4, ALU select width; also the PSR flag width.
- DATAWIDTH_INSTR, 32, instruction width.
- FETCH_TIMEOUT, 15, maximum cycles waiting for INSTR_VALID before a fault.

Ports:
- CC_SEQ_CLOCK_50  in  1  system clock, rising edge.
- CC_SEQ_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_SEQ_START  in  1  one-cycle pulse; starts execution from IDLE.
- CC_SEQ_INSTR  in  DATAWIDTH_INSTR  instruction word from memory.
- CC_SEQ_INSTR_VALID  in  1  memory ack; CC_SEQ_INSTR is valid this cycle.
- CC_SEQ_PSR  in  DATAWIDTH_ALU_SELECTION  PSR output {N,Z,V,C}.
- CC_SEQ_FETCH_REQ  out  1  instruction fetch request.
- CC_SEQ_ALU_SEL  out  DATAWIDTH_ALU_SELECTION  ALU operation select.
- CC_SEQ_SET_CONDITIONS  out  1  to PSR Set_Conditions_C.
- CC_SEQ_REG_WE  out  1  register file write enable.
- CC_SEQ_PC_INC  out  1  PC <= PC+4.
- CC_SEQ_PC_LOAD  out  1  PC <= branch target (datapath computes target).
- CC_SEQ_BRANCH_TAKEN  out  1  status pulse, coincident with PC_LOAD.
- CC_SEQ_BUSY  out  1  high in any state except IDLE, HALT and FAULT.
- CC_SEQ_HALTED  out  1  high in HALT.
- CC_SEQ_FAULT  out  1  high in FAULT (fetch timeout or illegal opcode).

Behaviour:
- Reset (asynchronous, CC_SEQ_RESET_InLow=0):
  - State goes to IDLE; IR, timeout counter and all outputs go to 0.
  - Reset takes effect mid-fetch or mid-exec with no completion of the current instruction.
- Outputs: all are decoded combinationally from state and IR. There are no extra pipeline stages.
- States and transitions:
  - IDLE: on START=1, go to FETCH; otherwise stay.
  - FETCH:
    - FETCH_REQ=1 and the counter increments each cycle.
    - If INSTR_VALID=1, latch IR <= INSTR, clear the counter and go to DECODE. VALID is accepted even in the same cycle the request first rises.
    - If the counter reaches FETCH_TIMEOUT with VALID=0, go to FAULT.
  - DECODE: one cycle, no outputs. Classifies IR:
    - IR==0 (unimp): go to HALT.
    - op=IR[31:30]=10 (arithmetic): go to EXEC.
    - op=00 with op2=IR[24:22]=010 (Bicc): go to BRANCH.
    - Anything else: go to FAULT.
  - EXEC: one cycle.
    - ALU_SEL=IR[22:19] (op3[3:0]); SET_CONDITIONS=IR[23] (op3 cc bit); REG_WE=1; PC_INC=1.
    - Then go to FETCH.
  - BRANCH: one cycle.
    - cond=IR[28:25] is evaluated on the CC_SEQ_PSR value sampled this cycle.
    - Taken: PC_LOAD=1, BRANCH_TAKEN=1. Not taken: PC_INC=1.
    - Then go to FETCH.
    - PC_LOAD and PC_INC are never high together.
  - HALT: stays until reset. START is ignored.
  - FAULT: stays until reset. START is ignored.
- Condition table (cond -> taken when):
  - 1000 always; 0000 never.
  - 0001 Z; 1001 !Z.
  - 0101 C; 1101 !C.
  - 0110 N; 1110 !N.
  - 0111 V; 1111 !V.
  - 0010 Z|(N^V); 1010 !(Z|(N^V)).
  - 0011 N^V; 1011 !(N^V).
  - 0100 C|Z; 1100 !(C|Z).
- PSR hazard: a cc op updates the PSR at the end of its EXEC cycle. A following branch evaluates at least 3 cycles later, so no stall logic is required.
- Throughput: arithmetic instruction = FETCH (>=1) + DECODE + EXEC = 3 cycles minimum; branch likewise.
- START while BUSY is ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, DECODE, EXEC, BRANCH, HALT, FAULT);
  - op field constants (OP_BRANCH=2'b00, OP_ARITH=2'b10, OP2_BICC=3'b010);
  - the 16 condition codes;
  - IR field bit positions.
- One sub-module, cc_cond_eval: purely combinational; PSR and cond in, taken out.

Test Plan:
- Reset mid-FETCH (RESET_InLow=0 for 2 cycles) -> all outputs 0, state IDLE; BUSY=0 until the next START.
- START, then memory returns 0x82804002 (op=10, op3=010000 addcc) with 0-cycle latency -> in EXEC: ALU_SEL=4'b0000, SET_CONDITIONS=1, REG_WE=1, PC_INC=1; the next FETCH_REQ comes 3 cycles after the first.
- Branch be (IR[28:25]=0001, op2=010): PSR=4'b0100 -> PC_LOAD=1, BRANCH_TAKEN=1, PC_INC=0. PSR=4'b0000 -> PC_INC=1, PC_LOAD=0. Sweep all 16 conds against all 16 PSR values using a reference model.
- Memory withholds VALID for FETCH_TIMEOUT=15 cycles -> FAULT=1, FETCH_REQ=0, BUSY=0. VALID on the 14th cycle -> normal DECODE.
- Instruction 0x00000000 -> HALTED=1 and sticky; a START pulse has no effect.
- Illegal op=11 word 0xC0000000 -> FAULT=1; no REG_WE, PC_INC or PC_LOAD pulse is ever emitted.
